// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter
//
// Multi-channel rising-edge detector and round-robin event scheduler.
// Each channel latches a pending flag on a rising edge of its level input.
// Pending events are handed one at a time to a single consumer over a
// valid/ready handshake. A rising edge that arrives while its channel is
// still pending (and not being accepted) sets a sticky overflow bit.
//
// Parameters:
//   N    number of input channels (2..16)
//   IDW  width of evt_id, equal to clog2(N)
//
// Ports:
//   clk           system clock, all state updates on posedge
//   rst           synchronous reset, active-high
//   en            global detect enable
//   sig[N]        per-channel level inputs, already synchronous to clk
//   mask[N]       per-channel detect enable, 1 = channel armed
//   evt_valid     event offered to the consumer
//   evt_ready     consumer accepts the offered event
//   evt_id[IDW]   channel index of the offered event
//   pending[N]    current pending flags
//   overflow[N]   sticky lost-edge flags
//   clr_overflow  clear all overflow bits
// ---------------------------------------------------------------------------
module edge_event_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   sig,
  input  logic [N-1:0]   mask,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overflow,
  input  logic           clr_overflow
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t         state_q;
  state_t         state_d;

  logic [N-1:0]   sig_d;
  logic [N-1:0]   rise;
  logic [N-1:0]   acc;
  logic [N-1:0]   pending_d;
  logic [N-1:0]   overflow_set;
  logic [N-1:0]   overflow_d;

  logic           handshake;
  logic           valid_d;
  logic [IDW-1:0] id_d;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] last_grant_d;

  logic           sel_found;
  logic [IDW-1:0] sel_id;
  logic [IDW-1:0] cand;

  // The delayed copy of sig tracks the input unconditionally, so re-enabling
  // a channel (mask or en) while its line is already high never looks like
  // a fresh rising edge.
  assign rise = sig & ~sig_d & mask & {N{en}};

  // Offer is only ever valid in OFFER, so qualifying on state is redundant
  // but keeps the handshake meaning obvious.
  assign handshake = (state_q == OFFER) & evt_valid & evt_ready;

  // One-hot view of the channel being accepted on this edge.
  always_comb begin
    acc = '0;
    if (handshake) begin
      acc[evt_id] = 1'b1;
    end
  end

  // A rise always (re)sets pending, which is why rise and accept on the same
  // channel in the same cycle leaves pending at 1 with no overflow. Overflow
  // only records a rise that lands on an event not being consumed now.
  always_comb begin
    pending_d    = (pending & ~acc) | rise;
    overflow_set = rise & pending & ~acc;
    overflow_d   = (clr_overflow ? '0 : overflow) | overflow_set;
  end

  // Edge-detect and event bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d    <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      sig_d    <= sig;
      pending  <= pending_d;
      overflow <= overflow_d;
    end
  end

  // Round-robin search: walk channels starting one past the last grant and
  // wrap around, taking the first pending one. The last candidate visited
  // is last_grant itself, so a lone channel can be granted repeatedly.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(last_grant) + k) % N);
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Scheduler state register. evt_valid and evt_id are registered so the
  // offer is glitch-free and stays stable for the whole OFFER phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      last_grant <= '0;
    end else begin
      state_q    <= state_d;
      evt_valid  <= valid_d;
      evt_id     <= id_d;
      last_grant <= last_grant_d;
    end
  end

  // Scheduler next-state logic. Returning to IDLE after every handshake
  // gives the mandatory one-cycle bubble between events; evt_ready in IDLE
  // has no effect because nothing is being offered.
  always_comb begin
    state_d      = state_q;
    valid_d      = evt_valid;
    id_d         = evt_id;
    last_grant_d = last_grant;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (sel_found) begin
          id_d    = sel_id;
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          valid_d      = 1'b0;
          last_grant_d = evt_id;
          state_d      = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_edge_event_arbiter
//
// Directed-vector bench for edge_event_arbiter (N=4). The stimulus process
// pushes each expected grant id into a queue; an independent monitor pops
// and compares on every accepted offer, and also watches the one-cycle
// bubble after each grant and evt_id stability while an offer is stalled.
// ---------------------------------------------------------------------------
module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk          = 1'b0;
  logic           rst          = 1'b1;
  logic           en           = 1'b1;
  logic [N-1:0]   sig          = '0;
  logic [N-1:0]   mask         = '1;
  logic           evt_ready    = 1'b0;
  logic           clr_overflow = 1'b0;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   overflow;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  logic           prev_hs    = 1'b0;
  logic           prev_stall = 1'b0;
  logic [IDW-1:0] prev_id    = '0;

  edge_event_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sig          (sig),
    .mask         (mask),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_id       (evt_id),
    .pending      (pending),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  // Single comparison point used by both the stimulus and monitor processes.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then return 1ns after the edge that sampled them.
  task automatic applyStimulus(input logic [N-1:0] s, input logic [N-1:0] m,
                               input logic e, input logic r, input logic c);
    sig          = s;
    mask         = m;
    en           = e;
    evt_ready    = r;
    clr_overflow = c;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst          = 1'b1;
    sig          = '0;
    mask         = '1;
    en           = 1'b1;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Wait (bounded) until every expected grant has been seen and the DUT is quiet.
  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && evt_valid === 1'b0 && pending === '0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(n >= 60), 32'd0);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (prev_hs) begin
        checkOutput("bubble_after_grant", 32'(evt_valid), 32'd0);
      end
      if (prev_stall && evt_valid === 1'b1) begin
        checkOutput("id_stable_while_stalled", 32'(evt_id), 32'(prev_id));
      end
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: got id %0d, expected no event", evt_id);
        end else begin
          checkOutput("grant_id", 32'(evt_id), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_hs    = (rst !== 1'b1) && evt_valid === 1'b1 && evt_ready === 1'b1;
    prev_stall = (rst !== 1'b1) && evt_valid === 1'b1 && evt_ready !== 1'b1;
    prev_id    = evt_id;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    applyReset();
    checkOutput("reset_evt_valid", 32'(evt_valid), 32'd0);
    checkOutput("reset_evt_id", 32'(evt_id), 32'd0);
    checkOutput("reset_pending", 32'(pending), 32'h0);
    checkOutput("reset_overflow", 32'(overflow), 32'h0);

    // 1: single rise on channel 2, level held afterwards
    $display("[TB] test 1: single edge");
    exp_q.push_back(2);
    applyStimulus(4'b0100, 4'hF, 1'b1, 1'b1, 1'b0);
    checkOutput("t1_pending_after_edge", 32'(pending), 32'h4);
    applyStimulus(4'b0100, 4'hF, 1'b1, 1'b1, 1'b0);
    checkOutput("t1_valid_next_cycle", 32'(evt_valid), 32'd1);
    checkOutput("t1_id_next_cycle", 32'(evt_id), 32'd2);
    waitIdle("t1_drain_timeout");
    repeat (5) applyStimulus(4'b0100, 4'hF, 1'b1, 1'b1, 1'b0);
    checkOutput("t1_held_level_no_pending", 32'(pending), 32'h0);

    // 2: simultaneous rises on 0,1,3 from last_grant=0
    $display("[TB] test 2: round robin");
    applyReset();
    exp_q.push_back(1);
    exp_q.push_back(3);
    exp_q.push_back(0);
    applyStimulus(4'b1011, 4'hF, 1'b1, 1'b1, 1'b0);
    checkOutput("t2_pending", 32'(pending), 32'hB);
    waitIdle("t2_drain_timeout");

    // 3: lost edge on channel 0, clear, then set-wins-over-clear
    $display("[TB] test 3: overflow");
    applyReset();
    exp_q.push_back(0);
    applyStimulus(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_overflow_set", 32'(overflow), 32'h1);
    checkOutput("t3_pending_held", 32'(pending), 32'h1);
    checkOutput("t3_offer_id", 32'(evt_id), 32'd0);
    applyStimulus(4'b0001, 4'hF, 1'b1, 1'b1, 1'b0);
    waitIdle("t3_drain_timeout");
    checkOutput("t3_overflow_sticky", 32'(overflow), 32'h1);
    applyStimulus(4'b0001, 4'hF, 1'b1, 1'b0, 1'b1);
    checkOutput("t3_overflow_cleared", 32'(overflow), 32'h0);
    exp_q.push_back(0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'hF, 1'b1, 1'b0, 1'b1);
    checkOutput("t3_set_wins_over_clear", 32'(overflow), 32'h1);
    applyStimulus(4'b0000, 4'hF, 1'b1, 1'b1, 1'b0);
    waitIdle("t3b_drain_timeout");

    // 4: new rise on channel 2 in the handshake cycle
    $display("[TB] test 4: rise during accept");
    applyReset();
    exp_q.push_back(2);
    exp_q.push_back(2);
    applyStimulus(4'b0100, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_offer_valid", 32'(evt_valid), 32'd1);
    checkOutput("t4_offer_id", 32'(evt_id), 32'd2);
    applyStimulus(4'b0100, 4'hF, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_pending_kept", 32'(pending), 32'h4);
    checkOutput("t4_no_overflow", 32'(overflow), 32'h0);
    applyStimulus(4'b0100, 4'hF, 1'b1, 1'b1, 1'b0);
    waitIdle("t4_drain_timeout");
    checkOutput("t4_no_overflow_end", 32'(overflow), 32'h0);

    // 5: masked / disabled edges and re-arming while high
    $display("[TB] test 5: mask and enable");
    applyReset();
    applyStimulus(4'b0000, 4'b1101, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0010, 4'b1101, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0010, 4'b1101, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_masked_no_pending", 32'(pending), 32'h0);
    applyStimulus(4'b0010, 4'hF, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0010, 4'hF, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_rearm_no_pending", 32'(pending), 32'h0);
    checkOutput("t5_rearm_no_valid", 32'(evt_valid), 32'd0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(1);
    applyStimulus(4'b0010, 4'hF, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_armed_pending", 32'(pending), 32'h2);
    waitIdle("t5_drain_timeout");
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0010, 4'hF, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0010, 4'hF, 1'b0, 1'b1, 1'b0);
    checkOutput("t5_disabled_no_pending", 32'(pending), 32'h0);
    applyStimulus(4'b0010, 4'hF, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0010, 4'hF, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_enable_no_pending", 32'(pending), 32'h0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(1);
    applyStimulus(4'b0010, 4'hF, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_enabled_pending", 32'(pending), 32'h2);
    waitIdle("t5b_drain_timeout");

    // 6: reset mid-offer (last_grant is 1 here, so pending 1010 offers 3)
    $display("[TB] test 6: reset during offer");
    applyStimulus(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b1010, 4'hF, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_offer_valid", 32'(evt_valid), 32'd1);
    checkOutput("t6_offer_id", 32'(evt_id), 32'd3);
    applyStimulus(4'b1010, 4'hF, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_overflow_before_reset", 32'(overflow), 32'hA);
    rst = 1'b1;
    sig = '0;
    @(posedge clk);
    #1;
    checkOutput("t6_valid_after_reset", 32'(evt_valid), 32'd0);
    checkOutput("t6_pending_after_reset", 32'(pending), 32'h0);
    checkOutput("t6_overflow_after_reset", 32'(overflow), 32'h0);
    rst = 1'b0;
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    applyStimulus(4'b1111, 4'hF, 1'b1, 1'b1, 1'b0);
    waitIdle("t6_drain_timeout");

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
